// File: rtl/add_pkg.sv
// Shared definitions for the nibble-serial adder slice:
// FSM state encoding, slice width and default operand width.
package add_pkg;

  localparam int NIB_W     = 4;
  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/rca_4b.sv
// 4-bit ripple-carry adder slice.
// Ports: A, B nibbles, C_in carry-in; S nibble sum, C_out carry-out.
module rca_4b
  import add_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             C_in,
  output logic [NIB_W-1:0] S,
  output logic             C_out
);

  logic [NIB_W:0] c;

  assign c[0] = C_in;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i])
                  | (c[i] & (A[i] ^ B[i]));
  end

  assign C_out = c[NIB_W];

endmodule

// File: rtl/nibble_serial_add.sv
// Multi-cycle adder: a+b+c_in, one nibble per cycle through
// one rca_4b. Ports: clk, rst (sync, high); in_valid/in_ready
// with a, b, c_in; out_valid/out_ready with sum, c_out, ovf.
module nibble_serial_add
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIBS = WIDTH / NIB_W;
  localparam int CW   = $clog2(NIBS);
  localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             nib_c;

  assign nib_a = a_r[cnt*NIB_W +: NIB_W];
  assign nib_b = b_r[cnt*NIB_W +: NIB_W];

  rca_4b u_rca (
    .A     (nib_a),
    .B     (nib_b),
    .C_in  (carry),
    .S     (nib_s),
    .C_out (nib_c)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= c_in;
            cnt   <= '0;
            sum   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          sum[cnt*NIB_W +: NIB_W] <= nib_s;
          carry <= nib_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // nib_s MSB is the final sum MSB here
            c_out     <= nib_c;
            ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1])
                      && (nib_s[NIB_W-1] != a_r[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add.sv
// Scoreboard bench for nibble_serial_add: directed cases
// plus randomized operations against an integer model.
module tb_nibble_serial_add;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         rnd = 1'b0;

  typedef struct packed {
    logic         c;
    logic         v;
    logic [W-1:0] s;
  } res_t;

  res_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  nibble_serial_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(
    logic [W-1:0] x, logic [W-1:0] y, logic ci);
    longint u;
    longint s;
    longint smax;
    res_t r;
    smax = (longint'(1) <<< (W - 1)) - 1;
    u = longint'(x) + longint'(y) + longint'(ci);
    s = longint'($signed(x)) + longint'($signed(y))
      + longint'(ci);
    r.s = u[W-1:0];
    r.c = u[W];
    r.v = (s > smax) || (s < -smax - 1);
    return r;
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: a result is consumed on the edge after it sees
  // out_valid && out_ready at the falling edge.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_result: got sum=%h c_out=%b ovf=%b, required none",
                   sum, c_out, ovf);
        end else begin
          e = exp_q.pop_front();
          if ({c_out, ovf, sum} !== e) begin
            n_bad++;
            $display("FAIL ERRORCHECK result: got c_out=%b ovf=%b sum=%h, required c_out=%b ovf=%b sum=%h",
                     c_out, ovf, sum, e.c, e.v, e.s);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(logic [W-1:0] x,
                      logic [W-1:0] y,
                      logic ci);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0, required 1");
      return;
    end
    a = x;
    b = y;
    c_in = ci;
    in_valid = 1'b1;
    exp_q.push_back(model(x, y, ci));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] c[6];
    c = '{16'h0000, 16'hFFFF, 16'h7FFF,
          16'h8000, 16'h0001, 16'h00FF};
    if ($urandom_range(0, 3) == 0)
      return c[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("latency_e%0d", k), out_valid, k == 4);
    end
    drain();

    send(16'h7FFF, 16'h0000, 1'b1);
    drain();

    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bp_valid_rise", out_valid, 1);
    a = 16'hAAAA;
    b = 16'h1111;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_sum", sum, 32'h5555);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    send(16'h0F0F, 16'h0101, 1'b0);
    drain();

    send(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_result", out_valid, 0);
    end
    send(16'h00FF, 16'h0F01, 1'b1);
    drain();

    rnd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom));
    end
    rnd = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add.md
Name: nibble_serial_add

Overview:
Multi-cycle adder that sums two WIDTH-bit operands plus carry-in four bits per cycle, reusing a single rca_4b slice. It feeds the slice one nibble pair and a stored carry each cycle, and captures the slice's sum and carry-out. Operands are accepted and results returned on valid/ready handshakes. It sits between an operand source (register file/bench driver) and a result consumer, as a low-area alternative to a full-width ripple adder.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
NIBS, WIDTH/4, derived; number of slice cycles per operation.

Ports:
clk  input  1  system clock, all state updates on posedge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operands present on a, b, c_in.
in_ready  output  1  block can accept operands; combinational, high iff state==IDLE.
a  input  WIDTH  operand A (unsigned/two's complement).
b  input  WIDTH  operand B.
c_in  input  1  carry-in.
out_valid  output  1  result registers hold a completed result.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  registered sum, meaningful only while out_valid=1.
c_out  output  1  registered unsigned carry-out of bit WIDTH-1.
ovf  output  1  registered signed overflow.

Behaviour:
- Reset (rst=1 at posedge): state<=IDLE, sum<=0, c_out<=0, ovf<=0, out_valid<=0, cnt<=0, carry<=0, operand regs<=0. rst wins over every other event.
- States: IDLE (00), BUSY (01), DONE (10); 11 is unreachable and recovers to IDLE next edge.
- IDLE: in_ready=1. If in_valid at posedge: latch a, b into a_r, b_r; carry<=c_in; cnt<=0; sum<=0; state<=BUSY. Otherwise hold.
- BUSY: in_ready=0; in_valid and operand inputs ignored. Slice inputs: A=a_r[4*cnt+3:4*cnt], B=b_r[same], C_in=carry. Each posedge: sum[4*cnt+3:4*cnt]<=slice S; carry<=slice C_out; cnt<=cnt+1.
- On the posedge where cnt==NIBS-1: also c_out<=slice C_out; ovf<=(a_r[W-1]==b_r[W-1]) && (final sum MSB != a_r[W-1]); out_valid<=1; state<=DONE.
- Latency: accept edge E0, out_valid high after edge E0+NIBS (4 edges for WIDTH=16).
- DONE: out_valid=1; sum, c_out and ovf are held stable until the handshake. The posedge with out_ready=1 sets out_valid<=0 and state<=IDLE. Next accept is possible no earlier than the following edge. Minimum period is NIBS+2 cycles per operation.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored, and the data is not queued.
- Arithmetic: {c_out,sum} == a+b+c_in modulo 2^(WIDTH+1). Carry ripples across nibbles only through the carry register, never combinationally across cycles.
- Reset mid-BUSY or mid-DONE: the operation is abandoned, no result is ever presented, and in_ready=1 in the cycle after the reset edge.

Decomposition:
- Shared package add_pkg holds:
  - state encodings IDLE/BUSY/DONE (2-bit),
  - NIB_W=4,
  - default WIDTH=16.
- One sub-module: a single rca_4b instance (ports A, B, C_in, S, C_out). The nibble mux, FSM, counter and result registers live in nibble_serial_add.

Test Plan:
- Reset held 2 cycles -> out_valid=0, sum=0x0000, c_out=0, ovf=0, in_ready=1 after the reset edge.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0; out_valid rises exactly 4 edges after the accept edge.
- a=0x7FFF, b=0x0000, c_in=1 (carry ripples through all nibbles) -> sum=0x8000, c_out=0, ovf=1.
- Backpressure, a=0x1234, b=0x4321, c_in=0, out_ready=0 for 5 cycles -> sum=0x5555 held stable with out_valid=1 and in_ready=0. In this window, in_valid with a=0xAAAA is ignored. Then out_ready=1 -> IDLE, and the next result is unaffected.
- rst asserted in the 2nd BUSY cycle -> out_valid never rises. Then a=0x00FF, b=0x0F01, c_in=1 -> sum=0x1001, c_out=0, ovf=0.
- 200 random operations with random in_valid/out_ready gaps -> each result matches the model a+b+c_in and the signed-overflow rule. Any mismatch prints "ERRORCHECK".
